// File: rtl/sine_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sine_burst_ctrl
// Description : Sequences the Sine_dac enable through a programmable number
//               of ON/OFF bursts measured in clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_burst_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_WIDTH-1:0]   on_cycles,
    input  logic [CNT_WIDTH-1:0]   off_cycles,
    input  logic [BURST_WIDTH-1:0] n_bursts,
    output logic                   dac_en,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [BURST_WIDTH-1:0] burst_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] c_burst_one = BURST_WIDTH'(1);

    state_t                   r_state;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic [CNT_WIDTH-1:0]     r_on;
    logic [CNT_WIDTH-1:0]     r_off;
    logic [BURST_WIDTH-1:0]   r_n;
    logic                     r_dac_en;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_cfg_err;
    logic [BURST_WIDTH-1:0]   r_burst_idx;

    state_t                   w_state_nxt;
    logic [CNT_WIDTH-1:0]     w_cnt_nxt;
    logic [CNT_WIDTH-1:0]     w_on_nxt;
    logic [CNT_WIDTH-1:0]     w_off_nxt;
    logic [BURST_WIDTH-1:0]   w_n_nxt;
    logic                     w_done_nxt;
    logic                     w_cfg_err_nxt;
    logic [BURST_WIDTH-1:0]   w_idx_nxt;
    logic [BURST_WIDTH-1:0]   w_idx_inc;

    assign w_idx_inc = r_burst_idx + c_burst_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_on        <= '0;
            r_off       <= '0;
            r_n         <= '0;
            r_dac_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_burst_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_on        <= w_on_nxt;
            r_off       <= w_off_nxt;
            r_n         <= w_n_nxt;
            // Outputs are registered from the next state so they align with it
            r_dac_en    <= (w_state_nxt == ST_ON);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
            r_burst_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_on_nxt      = r_on;
        w_off_nxt     = r_off;
        w_n_nxt       = r_n;
        w_done_nxt    = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_idx_nxt     = r_burst_idx;

        case (r_state)
            ST_IDLE: begin
                // Abort in the same cycle suppresses both acceptance and cfg_err
                if (start && !abort) begin
                    if (on_cycles != '0) begin
                        w_on_nxt    = on_cycles;
                        w_off_nxt   = off_cycles;
                        w_n_nxt     = n_bursts;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = on_cycles - c_cnt_one;
                        w_state_nxt = ST_ON;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end

            ST_ON: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_idx_nxt = w_idx_inc;
                    if ((r_n != '0) && (w_idx_inc == r_n)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_off != '0) begin
                        w_cnt_nxt   = r_off - c_cnt_one;
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_cnt_nxt   = r_on - c_cnt_one;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end

            ST_OFF: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_cnt_nxt   = r_on - c_cnt_one;
                    w_state_nxt = ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dac_en    = r_dac_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign burst_idx = r_burst_idx;

endmodule
`default_nettype wire

// File: tb/tb_sine_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_burst_ctrl
// Description : Scoreboard bench; expected output change events are queued by
//               the stimulus and matched by a monitor on every output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] on_cycles;
    logic [15:0] off_cycles;
    logic [7:0]  n_bursts;
    logic        dac_en;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [7:0]  burst_idx;

    sine_burst_ctrl #(.CNT_WIDTH(16), .BURST_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .on_cycles  (on_cycles),
        .off_cycles (off_cycles),
        .n_bursts   (n_bursts),
        .dac_en     (dac_en),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .burst_idx  (burst_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sig = {dac_en, busy, done, cfg_err}; an event is any change of sig or idx
    typedef struct {
        int         cyc;
        logic [3:0] sig;
        logic [7:0] idx;
    } ev_t;

    ev_t   q[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  mon_en = 1'b0;
    logic [11:0] prev = 12'h000;

    function automatic void push(input int c, input logic [3:0] s, input logic [7:0] i);
        ev_t e;
        e.cyc = c;
        e.sig = s;
        e.idx = i;
        q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] cur;
        ev_t e;
        cur = {dac_en, busy, done, cfg_err, burst_idx};
        if (mon_en && (cur !== prev)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: cycle %0d sig %b idx %0d, none expected",
                         cyc, cur[11:8], cur[7:0]);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.sig !== cur[11:8] || e.idx !== cur[7:0]) begin
                    n_err++;
                    $display("FAIL event: got cycle %0d sig %b idx %0d, expected cycle %0d sig %b idx %0d",
                             cyc, cur[11:8], cur[7:0], e.cyc, e.sig, e.idx);
                end
            end
            prev = cur;
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start is sampled at the next edge; s is the cycle whose outputs show it
    task automatic issue_start(output int s);
        start = 1'b1;
        goto(cyc + 1);
        s = cyc;
        start = 1'b0;
    endtask

    initial begin
        int s;
        int s2;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        on_cycles  = 16'd0;
        off_cycles = 16'd0;
        n_bursts   = 8'd0;
        #12;
        chk("reset_dac_en",    {7'd0, dac_en},  8'd0);
        chk("reset_busy",      {7'd0, busy},    8'd0);
        chk("reset_done",      {7'd0, done},    8'd0);
        chk("reset_cfg_err",   {7'd0, cfg_err}, 8'd0);
        chk("reset_burst_idx", burst_idx,       8'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        goto(cyc + 2);

        // Back-to-back bursts: on=5, off=0, n=3
        on_cycles = 16'd5; off_cycles = 16'd0; n_bursts = 8'd3;
        issue_start(s);
        push(s,      4'b1100, 8'd0);
        push(s + 5,  4'b1100, 8'd1);
        push(s + 10, 4'b1100, 8'd2);
        push(s + 15, 4'b0010, 8'd3);
        push(s + 16, 4'b0000, 8'd3);
        goto(s + 20);

        // Nominal: on=7000, off=3000, n=2
        on_cycles = 16'd7000; off_cycles = 16'd3000; n_bursts = 8'd2;
        issue_start(s);
        push(s,         4'b1100, 8'd0);
        push(s + 7000,  4'b0100, 8'd1);
        push(s + 10000, 4'b1100, 8'd1);
        push(s + 17000, 4'b0010, 8'd2);
        push(s + 17001, 4'b0000, 8'd2);
        goto(s + 17005);

        // Abort during OFF: on=100, off=50, continuous
        on_cycles = 16'd100; off_cycles = 16'd50; n_bursts = 8'd0;
        issue_start(s);
        push(s,       4'b1100, 8'd0);
        push(s + 100, 4'b0100, 8'd1);
        goto(s + 119);
        abort = 1'b1;
        push(s + 120, 4'b0000, 8'd1);
        goto(s + 120);
        abort = 1'b0;
        goto(s + 130);

        // Rejected start with on=0
        on_cycles = 16'd0; n_bursts = 8'd1;
        issue_start(s);
        push(s,     4'b0001, 8'd1);
        push(s + 1, 4'b0000, 8'd1);
        goto(s + 5);

        // Start and abort together in IDLE: nothing happens
        on_cycles = 16'd4;
        start = 1'b1;
        abort = 1'b1;
        goto(cyc + 1);
        start = 1'b0;
        abort = 1'b0;
        goto(cyc + 6);

        // Start during ON ignored, config changes shadowed, restart on done cycle
        on_cycles = 16'd10; off_cycles = 16'd5; n_bursts = 8'd2;
        issue_start(s);
        push(s,      4'b1100, 8'd0);
        push(s + 10, 4'b0100, 8'd1);
        push(s + 15, 4'b1100, 8'd1);
        push(s + 25, 4'b0010, 8'd2);
        goto(s + 3);
        on_cycles = 16'd2; off_cycles = 16'd1; n_bursts = 8'd1;
        start = 1'b1;
        goto(s + 4);
        start = 1'b0;
        goto(s + 25);
        on_cycles = 16'd3; off_cycles = 16'd0; n_bursts = 8'd1;
        start = 1'b1;
        push(s + 26, 4'b1100, 8'd0);
        push(s + 29, 4'b0010, 8'd1);
        push(s + 30, 4'b0000, 8'd1);
        goto(s + 26);
        start = 1'b0;
        goto(s + 35);

        // Wrap: on=1, off=1, continuous for 600 cycles, on_cycles changed mid-run
        on_cycles = 16'd1; off_cycles = 16'd1; n_bursts = 8'd0;
        issue_start(s);
        push(s, 4'b1100, 8'd0);
        for (int h = 1; h < 600; h++)
            push(s + h, (h % 2 == 1) ? 4'b0100 : 4'b1100, 8'((h + 1) / 2));
        goto(s + 100);
        on_cycles  = 16'd7;
        off_cycles = 16'd9;
        goto(s + 599);
        abort = 1'b1;
        push(s + 600, 4'b0000, 8'd44);
        goto(s + 600);
        abort = 1'b0;
        goto(s + 605);

        // Asynchronous reset mid-ON with burst_idx nonzero
        on_cycles = 16'd5; off_cycles = 16'd0; n_bursts = 8'd0;
        issue_start(s);
        push(s,     4'b1100, 8'd0);
        push(s + 5, 4'b1100, 8'd1);
        goto(s + 10);
        #2;
        push(s + 10, 4'b0000, 8'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_dac_en",    {7'd0, dac_en},  8'd0);
        chk("async_rst_busy",      {7'd0, busy},    8'd0);
        chk("async_rst_burst_idx", burst_idx,       8'd0);
        goto(s + 12);
        rst = 1'b0;
        goto(s + 14);

        // FSM usable after reset release
        on_cycles = 16'd2; off_cycles = 16'd0; n_bursts = 8'd1;
        issue_start(s2);
        push(s2,     4'b1100, 8'd0);
        push(s2 + 2, 4'b0010, 8'd1);
        push(s2 + 3, 4'b0000, 8'd1);
        goto(s2 + 8);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: %0d expected events never seen, next at cycle %0d",
                     q.size(), q[0].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
